// File: rtl/conv_quant_pool.sv
// Requantizes the conv core's signed accumulator stream to unsigned bytes (round, shift, ReLU,
// saturate) and applies 2x2 / stride-2 max pooling, emitting one byte per completed pool.
module conv_quant_pool #(
    parameter int IN_W       = 39,
    parameter int FRAC_SHIFT = 16,
    parameter int IMG_W      = 22,
    parameter int IMG_H      = 22
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_valid,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    output logic                   frame_done
);

    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int BD       = IMG_W / 2;
    localparam int BW       = (BD > 1) ? $clog2(BD) : 1;
    localparam int RB_DEPTH = (BD > 1) ? BD : 2;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] POOL_COL_LAST = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [RW-1:0] POOL_ROW_LAST = RW'(2 * (IMG_H / 2) - 1);

    localparam logic signed [IN_W:0] RND     = (IN_W + 1)'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W + 1)'(255);

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    function automatic logic [7:0] requant(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] s;
        logic signed [IN_W:0] q;
        s = {x[IN_W-1], x};
        s = s + RND;
        q = s >>> FRAC_SHIFT;
        if (q[IN_W]) begin
            return 8'd0;
        end else if (q > SAT_MAX) begin
            return 8'hFF;
        end else begin
            return q[7:0];
        end
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          accept;

    logic          vld_p1_q;
    logic [7:0]    quant_p1_q;
    logic [CW-1:0] col_p1_q;
    logic [RW-1:0] row_p1_q;

    logic [7:0]    hold_q;
    logic [7:0]    rowbuf_q [RB_DEPTH];
    logic [7:0]    out_data_q;
    logic          out_valid_q;
    logic          frame_done_q;

    logic [BW-1:0] bidx;
    logic [7:0]    pair_max;
    logic [7:0]    quad_max;
    logic          last_pool;

    assign accept = in_valid && !clear;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Stage 1: requantize and tag each accepted sample with its map position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            vld_p1_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            quant_p1_q <= requant(in_data);
            col_p1_q   <= col_q;
            row_p1_q   <= row_q;
        end
    end

    assign bidx      = BW'(col_p1_q >> 1);
    assign pair_max  = max8(hold_q, quant_p1_q);
    assign quad_max  = max8(pair_max, rowbuf_q[bidx]);
    assign last_pool = (col_p1_q == POOL_COL_LAST) && (row_p1_q == POOL_ROW_LAST);

    // Stage 2: horizontal pair max, vertical merge through the row buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < RB_DEPTH; i++) begin
                rowbuf_q[i] <= '0;
            end
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (clear) begin
                hold_q <= '0;
                for (int i = 0; i < RB_DEPTH; i++) begin
                    rowbuf_q[i] <= '0;
                end
            end else if (vld_p1_q) begin
                if (!col_p1_q[0]) begin
                    hold_q <= quant_p1_q;
                end else if (!row_p1_q[0]) begin
                    rowbuf_q[bidx] <= pair_max;
                end else begin
                    out_data_q   <= quad_max;
                    out_valid_q  <= 1'b1;
                    frame_done_q <= last_pool;
                end
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_quant_pool.sv
// Directed bench for conv_quant_pool: 2x2 map for requantization, 4x4 map for pooling,
// clear and reset, 22x22 map for back-to-back random frames against a reference model.
module tb_conv_quant_pool;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic clear = 1'b0;

    logic signed [38:0] a_data = '0;
    logic signed [38:0] b_data = '0;
    logic signed [38:0] c_data = '0;
    logic a_valid = 1'b0;
    logic b_valid = 1'b0;
    logic c_valid = 1'b0;
    logic [7:0] a_out, b_out, c_out;
    logic a_ov, b_ov, c_ov;
    logic a_fd, b_fd, c_fd;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    int a_vals[$];
    int a_fds[$];
    int b_vals[$];
    int b_cycs[$];
    int b_fds[$];
    int b_fdcnt = 0;
    int c_vals[$];
    int c_fds[$];
    int c_fdcnt = 0;

    localparam logic signed [38:0] FILL = -39'sd1073741824;

    conv_quant_pool #(.IN_W(39), .FRAC_SHIFT(16), .IMG_W(2), .IMG_H(2)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(a_data), .in_valid(a_valid),
        .out_data(a_out), .out_valid(a_ov), .frame_done(a_fd));

    conv_quant_pool #(.IN_W(39), .FRAC_SHIFT(16), .IMG_W(4), .IMG_H(4)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(b_data), .in_valid(b_valid),
        .out_data(b_out), .out_valid(b_ov), .frame_done(b_fd));

    conv_quant_pool #(.IN_W(39), .FRAC_SHIFT(16), .IMG_W(22), .IMG_H(22)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(c_data), .in_valid(c_valid),
        .out_data(c_out), .out_valid(c_ov), .frame_done(c_fd));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_ov) begin
            a_vals.push_back(int'(a_out));
            a_fds.push_back(int'(a_fd));
        end
        if (b_ov) begin
            b_vals.push_back(int'(b_out));
            b_cycs.push_back(cyc);
            b_fds.push_back(int'(b_fd));
        end
        if (b_fd) b_fdcnt++;
        if (c_ov) begin
            c_vals.push_back(int'(c_out));
            c_fds.push_back(int'(c_fd));
        end
        if (c_fd) c_fdcnt++;
    end

    function automatic int ref_q(input longint v);
        longint t;
        t = (v + 64'sd32768) >>> 16;
        if (t < 0) return 0;
        if (t > 255) return 255;
        return int'(t);
    endfunction

    task automatic send_b(input int k, input logic clr, output int dc);
        @(negedge clk);
        b_data  = 39'(k) << 16;
        b_valid = 1'b1;
        clear   = clr;
        dc      = cyc;
    endtask

    task automatic idle_b(input int n);
        repeat (n) begin
            @(negedge clk);
            b_valid = 1'b0;
            clear   = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (a_out !== 8'd0) begin bad++; $display("FAIL reset_a_data got=%0d want=0", a_out); end
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b want=0", a_ov); end
        total++; if (a_fd !== 1'b0) begin bad++; $display("FAIL reset_a_fd got=%b want=0", a_fd); end
        total++; if (b_out !== 8'd0) begin bad++; $display("FAIL reset_b_data got=%0d want=0", b_out); end
        total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL reset_b_valid got=%b want=0", b_ov); end
        total++; if (b_fd !== 1'b0) begin bad++; $display("FAIL reset_b_fd got=%b want=0", b_fd); end
        total++; if (c_out !== 8'd0) begin bad++; $display("FAIL reset_c_data got=%0d want=0", c_out); end
        total++; if (c_ov !== 1'b0) begin bad++; $display("FAIL reset_c_valid got=%b want=0", c_ov); end
        total++; if (c_fd !== 1'b0) begin bad++; $display("FAIL reset_c_fd got=%b want=0", c_fd); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL idle_b_valid got=%b want=0", b_ov); end
    endtask

    task automatic test_quant();
        logic signed [38:0] vec[9];
        int ev[9];
        int base;
        base = a_vals.size();
        vec[0] = 39'sh18000;        ev[0] = 2;
        vec[1] = 39'sh8000;         ev[1] = 1;
        vec[2] = -39'sh8000;        ev[2] = 0;
        vec[3] = -39'sh10000;       ev[3] = 0;
        vec[4] = 39'sd19660800;     ev[4] = 255;
        vec[5] = 39'sh3F_FFFF_FFFF; ev[5] = 255;
        vec[6] = 39'sh7FFF;         ev[6] = 0;
        vec[7] = 39'shFE7FFF;       ev[7] = 254;
        vec[8] = 39'sh17FFF;        ev[8] = 1;
        for (int i = 0; i < 9; i++) begin
            for (int p = 0; p < 4; p++) begin
                @(negedge clk);
                a_data  = (p == i % 4) ? vec[i] : FILL;
                a_valid = 1'b1;
            end
        end
        repeat (4) begin
            @(negedge clk);
            a_valid = 1'b0;
        end
        total++;
        if (a_vals.size() - base != 9) begin
            bad++; $display("FAIL quant_count got=%0d want=9", a_vals.size() - base);
        end
        for (int i = 0; i < 9; i++) begin
            if (base + i < a_vals.size()) begin
                total++;
                if (a_vals[base+i] != ev[i]) begin
                    bad++; $display("FAIL quant_val[%0d] got=%0d want=%0d", i, a_vals[base+i], ev[i]);
                end
                total++;
                if (a_fds[base+i] != 1) begin
                    bad++; $display("FAIL quant_fd[%0d] got=%0d want=1", i, a_fds[base+i]);
                end
            end
        end
    endtask

    task automatic test_pool();
        int dcs[16];
        int ek[4] = '{5, 7, 13, 15};
        int base;
        int fd0;
        base = b_vals.size();
        fd0  = b_fdcnt;
        for (int k = 0; k < 16; k++) send_b(k, 1'b0, dcs[k]);
        idle_b(4);
        total++;
        if (b_vals.size() - base != 4) begin
            bad++; $display("FAIL pool_count got=%0d want=4", b_vals.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            if (base + i < b_vals.size()) begin
                total++;
                if (b_vals[base+i] != ek[i]) begin
                    bad++; $display("FAIL pool_val[%0d] got=%0d want=%0d", i, b_vals[base+i], ek[i]);
                end
                total++;
                if (b_cycs[base+i] != dcs[ek[i]] + 2) begin
                    bad++; $display("FAIL pool_lat[%0d] got=%0d want=%0d", i, b_cycs[base+i], dcs[ek[i]] + 2);
                end
                total++;
                if (b_fds[base+i] != ((i == 3) ? 1 : 0)) begin
                    bad++; $display("FAIL pool_fd[%0d] got=%0d want=%0d", i, b_fds[base+i], (i == 3) ? 1 : 0);
                end
            end
        end
        total++;
        if (b_fdcnt - fd0 != 1) begin
            bad++; $display("FAIL pool_fdcnt got=%0d want=1", b_fdcnt - fd0);
        end
    endtask

    task automatic test_gaps();
        int dcs[16];
        int ek[4] = '{5, 7, 13, 15};
        int base;
        int fd0;
        int gap_at;
        base   = b_vals.size();
        fd0    = b_fdcnt;
        gap_at = $urandom_range(14, 0);
        for (int k = 0; k < 16; k++) begin
            send_b(k, 1'b0, dcs[k]);
            idle_b(1);
            if (k == gap_at) idle_b(10);
        end
        idle_b(4);
        total++;
        if (b_vals.size() - base != 4) begin
            bad++; $display("FAIL gap_count got=%0d want=4", b_vals.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            if (base + i < b_vals.size()) begin
                total++;
                if (b_vals[base+i] != ek[i]) begin
                    bad++; $display("FAIL gap_val[%0d] got=%0d want=%0d", i, b_vals[base+i], ek[i]);
                end
                total++;
                if (b_cycs[base+i] != dcs[ek[i]] + 2) begin
                    bad++; $display("FAIL gap_lat[%0d] got=%0d want=%0d", i, b_cycs[base+i], dcs[ek[i]] + 2);
                end
                total++;
                if (b_fds[base+i] != ((i == 3) ? 1 : 0)) begin
                    bad++; $display("FAIL gap_fd[%0d] got=%0d want=%0d", i, b_fds[base+i], (i == 3) ? 1 : 0);
                end
            end
        end
        total++;
        if (b_fdcnt - fd0 != 1) begin
            bad++; $display("FAIL gap_fdcnt got=%0d want=1", b_fdcnt - fd0);
        end
    endtask

    task automatic test_clear();
        int dcs[32];
        int ek[6] = '{5, 7, 21, 23, 29, 31};
        int base;
        int fd0;
        base = b_vals.size();
        fd0  = b_fdcnt;
        for (int k = 0; k < 9; k++) send_b(k, 1'b0, dcs[k]);
        send_b(9, 1'b1, dcs[9]);
        for (int k = 16; k < 32; k++) send_b(k, 1'b0, dcs[k]);
        idle_b(4);
        total++;
        if (b_vals.size() - base != 6) begin
            bad++; $display("FAIL clear_count got=%0d want=6", b_vals.size() - base);
        end
        for (int i = 0; i < 6; i++) begin
            if (base + i < b_vals.size()) begin
                total++;
                if (b_vals[base+i] != ek[i]) begin
                    bad++; $display("FAIL clear_val[%0d] got=%0d want=%0d", i, b_vals[base+i], ek[i]);
                end
                total++;
                if (b_cycs[base+i] != dcs[ek[i]] + 2) begin
                    bad++; $display("FAIL clear_lat[%0d] got=%0d want=%0d", i, b_cycs[base+i], dcs[ek[i]] + 2);
                end
                total++;
                if (b_fds[base+i] != ((i == 5) ? 1 : 0)) begin
                    bad++; $display("FAIL clear_fd[%0d] got=%0d want=%0d", i, b_fds[base+i], (i == 5) ? 1 : 0);
                end
            end
        end
        total++;
        if (b_fdcnt - fd0 != 1) begin
            bad++; $display("FAIL clear_fdcnt got=%0d want=1", b_fdcnt - fd0);
        end
    endtask

    task automatic test_reset_mid();
        int dcs[48];
        int ek[5] = '{5, 37, 39, 45, 47};
        int base;
        int fd0;
        base = b_vals.size();
        fd0  = b_fdcnt;
        for (int k = 0; k < 7; k++) send_b(k, 1'b0, dcs[k]);
        @(negedge clk);
        b_valid = 1'b0;
        #2 rst_n = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (r > 0) @(negedge clk);
            #1;
            total++; if (b_out !== 8'd0) begin bad++; $display("FAIL rstmid_data[%0d] got=%0d want=0", r, b_out); end
            total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL rstmid_valid[%0d] got=%b want=0", r, b_ov); end
            total++; if (b_fd !== 1'b0) begin bad++; $display("FAIL rstmid_fd[%0d] got=%b want=0", r, b_fd); end
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 32; k < 48; k++) send_b(k, 1'b0, dcs[k]);
        idle_b(4);
        total++;
        if (b_vals.size() - base != 5) begin
            bad++; $display("FAIL rstmid_count got=%0d want=5", b_vals.size() - base);
        end
        for (int i = 0; i < 5; i++) begin
            if (base + i < b_vals.size()) begin
                total++;
                if (b_vals[base+i] != ek[i]) begin
                    bad++; $display("FAIL rstmid_val[%0d] got=%0d want=%0d", i, b_vals[base+i], ek[i]);
                end
                total++;
                if (b_fds[base+i] != ((i == 4) ? 1 : 0)) begin
                    bad++; $display("FAIL rstmid_fd[%0d] got=%0d want=%0d", i, b_fds[base+i], (i == 4) ? 1 : 0);
                end
            end
        end
        total++;
        if (b_fdcnt - fd0 != 1) begin
            bad++; $display("FAIL rstmid_fdcnt got=%0d want=1", b_fdcnt - fd0);
        end
    endtask

    task automatic test_back_to_back();
        longint stim[968];
        int ev[242];
        int base;
        int fd0;
        int m;
        int off;
        base = c_vals.size();
        fd0  = c_fdcnt;
        for (int i = 0; i < 968; i++) begin
            stim[i] = longint'($urandom_range(40000000, 0)) - 64'sd20000000;
            if ($urandom_range(15, 0) == 0) begin
                stim[i] = ($urandom_range(1, 0) == 1) ? 64'sd274877906943 : -64'sd274877906944;
            end
        end
        for (int f = 0; f < 2; f++) begin
            for (int pr = 0; pr < 11; pr++) begin
                for (int pc = 0; pc < 11; pc++) begin
                    off = f * 484 + (2 * pr) * 22 + 2 * pc;
                    m = ref_q(stim[off]);
                    if (ref_q(stim[off + 1]) > m) m = ref_q(stim[off + 1]);
                    if (ref_q(stim[off + 22]) > m) m = ref_q(stim[off + 22]);
                    if (ref_q(stim[off + 23]) > m) m = ref_q(stim[off + 23]);
                    ev[f * 121 + pr * 11 + pc] = m;
                end
            end
        end
        for (int i = 0; i < 968; i++) begin
            @(negedge clk);
            c_data  = 39'(stim[i]);
            c_valid = 1'b1;
        end
        repeat (4) begin
            @(negedge clk);
            c_valid = 1'b0;
        end
        total++;
        if (c_vals.size() - base != 242) begin
            bad++; $display("FAIL b2b_count got=%0d want=242", c_vals.size() - base);
        end
        for (int i = 0; i < 242; i++) begin
            if (base + i < c_vals.size()) begin
                total++;
                if (c_vals[base+i] != ev[i]) begin
                    bad++; $display("FAIL b2b_val[%0d] got=%0d want=%0d", i, c_vals[base+i], ev[i]);
                end
                total++;
                if (c_fds[base+i] != ((i % 121 == 120) ? 1 : 0)) begin
                    bad++; $display("FAIL b2b_fd[%0d] got=%0d want=%0d", i, c_fds[base+i], (i % 121 == 120) ? 1 : 0);
                end
            end
        end
        total++;
        if (c_fdcnt - fd0 != 2) begin
            bad++; $display("FAIL b2b_fdcnt got=%0d want=2", c_fdcnt - fd0);
        end
    endtask

    initial begin
        test_reset();
        test_quant();
        test_pool();
        test_gaps();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
